// File: rtl/ppt_pkg.sv
// Shared types and widths for the pulse-train burst sequencer.
package ppt_pkg;

  localparam int PERIOD_W = 15;
  localparam int COUNT_W  = 8;
  localparam int CLKDIV_W = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    GAP    = 3'd4,
    FINISH = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    FLD_PERIOD = 2'd0,
    FLD_WIDTH  = 2'd1,
    FLD_COUNT  = 2'd2,
    FLD_CLKDIV = 2'd3
  } field_t;

  // One segment: 15 + 15 + 8 + 5 = 43 bits.
  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] width;
    logic [COUNT_W-1:0]  count;
    logic [CLKDIV_W-1:0] clk_div;
  } seg_entry_t;

endpackage

// File: rtl/ppt_seg_table.sv
// Segment table: DEPTH entries, one field-wise write port, one async read port.
module ppt_seg_table
  import ppt_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int SEG_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [SEG_W-1:0]    wseg,
  input  logic [1:0]          field,
  input  logic [PERIOD_W-1:0] wdata,
  input  logic [SEG_W-1:0]    rseg,
  output seg_entry_t          rdata
);

  seg_entry_t mem [DEPTH];

  // Field-wise write of one entry; whole table cleared on reset.
  // NOTE: entries must read back as 0 after reset, so the table is a reset register file rather than a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      case (field)
        FLD_PERIOD: mem[wseg].period  <= wdata;
        FLD_WIDTH:  mem[wseg].width   <= wdata;
        FLD_COUNT:  mem[wseg].count   <= wdata[COUNT_W-1:0];
        FLD_CLKDIV: mem[wseg].clk_div <= wdata[CLKDIV_W-1:0];
        default:    ;
      endcase
    end
  end

  assign rdata = mem[rseg];

endmodule

// File: rtl/ppt_burst_sequencer.sv
// Plays a table of pulse-train segments through the generator/counter pair,
// with a programmable gap between segments and a finite or infinite loop count.
module ppt_burst_sequencer
  import ppt_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter int  GAP_W  = 16,
  parameter int  LOOP_W = 8,
  localparam int SEG_W  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [SEG_W-1:0]    cfg_seg,
  input  logic [1:0]          cfg_field,
  input  logic [PERIOD_W-1:0] cfg_wdata,
  input  logic [SEG_W:0]      num_segs,
  input  logic [GAP_W-1:0]    gap_cycles,
  input  logic [LOOP_W-1:0]   loops,
  input  logic                start,
  input  logic                abort,
  input  logic                pc_done,
  output logic [PERIOD_W-1:0] period,
  output logic [PERIOD_W-1:0] width,
  output logic [COUNT_W-1:0]  count,
  output logic [CLKDIV_W-1:0] clk_div,
  output logic                run,
  output logic                busy,
  output logic                seq_done,
  output logic                cfg_err,
  output logic [SEG_W-1:0]    cur_seg
);

  localparam logic [SEG_W:0] DEPTH_CNT = (SEG_W+1)'(DEPTH);

  state_t          state, next_state;
  seg_entry_t      tbl_rd;
  logic            tbl_we;

  // Run configuration captured at start; later input changes do not disturb a run.
  logic [SEG_W:0]  num_segs_q;
  logic [GAP_W-1:0]  gap_q;
  logic [LOOP_W-1:0] loops_q;

  logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
  logic [LOOP_W-1:0] loop_cnt, loop_cnt_d;
  logic [SEG_W-1:0]  seg_d;
  logic [SEG_W:0]    seg_plus1;
  logic              last_seg;
  logic              adv_finish;
  logic              advance;
  logic              sample_cfg;

  // Table writes are only honoured while idle.
  assign tbl_we = cfg_we && (state == IDLE);

  ppt_seg_table #(.DEPTH(DEPTH)) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .wseg  (cfg_seg),
    .field (cfg_field),
    .wdata (cfg_wdata),
    .rseg  (cur_seg),
    .rdata (tbl_rd)
  );

  assign seg_plus1  = {1'b0, cur_seg} + (SEG_W+1)'(1);
  assign last_seg   = seg_plus1 >= num_segs_q;
  assign adv_finish = last_seg && (loops_q != '0) && (loop_cnt == LOOP_W'(1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic, segment advance and counter updates.
  // NOTE: every variable gets a default before the case so no latch can be inferred.
  always_comb begin
    next_state = state;
    seg_d      = cur_seg;
    gap_cnt_d  = gap_cnt;
    loop_cnt_d = loop_cnt;
    sample_cfg = 1'b0;
    advance    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          sample_cfg = 1'b1;
          seg_d      = '0;
          loop_cnt_d = loops;
          next_state = (num_segs == '0) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        // An empty segment is skipped without ever raising run.
        if (tbl_rd.count == '0) advance = 1'b1;
        else                    next_state = RUN;
      end
      RUN: begin
        if (pc_done) next_state = DRAIN;
      end
      DRAIN: begin
        // Wait for the counter to drop done after run fell.
        if (!pc_done) begin
          if (gap_q == '0) begin
            advance = 1'b1;
          end else begin
            next_state = GAP;
            gap_cnt_d  = gap_q - GAP_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) advance = 1'b1;
        else               gap_cnt_d = gap_cnt - GAP_W'(1);
      end
      FINISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase

    if (advance) begin
      if (adv_finish) begin
        next_state = FINISH;
      end else begin
        next_state = LOAD;
        seg_d      = last_seg ? '0 : seg_plus1[SEG_W-1:0];
        if (last_seg && (loops_q != '0) && (loop_cnt != '0))
          loop_cnt_d = loop_cnt - LOOP_W'(1);
      end
    end

    // Abort overrides everything, including a coincident start.
    if (abort) begin
      next_state = IDLE;
      seg_d      = cur_seg;
      gap_cnt_d  = gap_cnt;
      loop_cnt_d = loop_cnt;
      sample_cfg = 1'b0;
    end
  end

  // Counters, captured configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_segs_q <= '0;
      gap_q      <= '0;
      loops_q    <= '0;
      gap_cnt    <= '0;
      loop_cnt   <= '0;
      cur_seg    <= '0;
      period     <= '0;
      width      <= '0;
      count      <= '0;
      clk_div    <= '0;
      run        <= 1'b0;
      busy       <= 1'b0;
      seq_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      gap_cnt  <= gap_cnt_d;
      loop_cnt <= loop_cnt_d;
      cur_seg  <= seg_d;
      if (sample_cfg) begin
        num_segs_q <= (num_segs > DEPTH_CNT) ? DEPTH_CNT : num_segs;
        gap_q      <= gap_cycles;
        loops_q    <= loops;
      end
      // Parameters change only on a segment load, so they hold through IDLE and abort.
      if (state == LOAD && !abort) begin
        period  <= tbl_rd.period;
        width   <= tbl_rd.width;
        count   <= tbl_rd.count;
        clk_div <= tbl_rd.clk_div;
      end
      run      <= (next_state == RUN);
      busy     <= (next_state != IDLE);
      seq_done <= (state == FINISH) && !abort;
      if (cfg_we && state != IDLE)
        cfg_err <= 1'b1;
      else if (state == IDLE && start && !abort)
        cfg_err <= 1'b0;
    end
  end

endmodule
